// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing the async FIFO write port; one IDLE bubble per grant.
// req_ready/winc are combinational from the registered grant and wfull; wfull stalls the holder without ending its burst.
module async_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                            wclk,
  input  logic                            wrst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            winc,
  output logic [DATA_WIDTH-1:0]           wdata,
  input  logic                            wfull,
  output logic                            grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant, grant_nxt;
  logic [CW-1:0]      beat_cnt, beat_cnt_nxt;
  logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]      g_idx, pick_idx, cand;
  logic               pick_vld, accept, last_beat;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) g_idx = IW'(i);
  end

  // First valid requester strictly after the last holder, wrapping around.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign accept    = (state == BUSY) && req_valid[g_idx] && !wfull;
  assign last_beat = (beat_cnt == CW'(BURST_LEN - 1));

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    beat_cnt_nxt = beat_cnt;
    rr_ptr_nxt   = rr_ptr;
    req_ready    = '0;
    winc         = 1'b0;
    wdata        = '0;
    grant_valid  = 1'b0;
    grant_id     = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt    = NUM_REQ'(1) << pick_idx;
          beat_cnt_nxt = '0;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        req_ready   = grant & {NUM_REQ{!wfull}};
        winc        = accept;
        wdata       = req_data[int'(g_idx)*DATA_WIDTH +: DATA_WIDTH];
        grant_valid = 1'b1;
        grant_id    = g_idx;
        // A dropped valid ends the burst even while wfull is stalling it.
        if (!req_valid[g_idx] || (accept && last_beat)) begin
          state_nxt    = IDLE;
          grant_nxt    = '0;
          beat_cnt_nxt = '0;
          rr_ptr_nxt   = g_idx;
        end else if (accept) begin
          beat_cnt_nxt = beat_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state    <= IDLE;
      grant    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= IW'(NUM_REQ - 1);
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      beat_cnt <= beat_cnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

endmodule

// File: doc/async_fifo_wr_arbiter.md
Name: async_fifo_wr_arbiter

Overview:
- Round-robin, burst-locking arbiter that shares the single write port of the async FIFO between NUM_REQ requesters in the write-clock domain.
- Each requester uses a valid/ready handshake.
- The arbiter drives winc/wdata into the FIFO and applies wfull backpressure to whichever requester holds the grant.
- It sits directly in front of the FIFO write side; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, FIFO data width.
- BURST_LEN, 4, maximum beats a requester may write per grant (1..16).

Ports:
- wclk  in  1  write-domain clock; all logic is on its rising edge.
- wrst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept.
- winc  out  1  FIFO write enable.
- wdata  out  DATA_WIDTH  FIFO write data.
- wfull  in  1  FIFO full flag, synchronous to wclk.
- grant_valid  out  1  a requester currently holds the grant.
- grant_id  out  $clog2(NUM_REQ)  index of the granted requester; 0 when grant_valid=0.

Behaviour:
- Reset (asynchronous, wrst=1):
  - state=IDLE, grant one-hot=0, beat_cnt=0, rr_ptr=NUM_REQ-1.
  - Outputs: req_ready=0, winc=0, wdata=0, grant_valid=0, grant_id=0.
  - Reset asserted mid-burst drops the grant immediately with no further winc.
  - After release, requester 0 has first priority.
- States: IDLE, BUSY. State, grant, beat_cnt and rr_ptr are registered.
- IDLE:
  - If any req_valid is high, select the first valid index searching from rr_ptr+1 modulo NUM_REQ.
  - Load grant, clear beat_cnt, go to BUSY on the next edge.
  - No data is accepted in IDLE, so each grant costs one arbitration bubble cycle.
- BUSY, requester g granted:
  - req_ready[g] = !wfull. All other req_ready bits are 0.
  - req_ready is combinational from registered grant and wfull only; it never depends on req_valid.
  - A beat is accepted when req_valid[g] && req_ready[g].
  - winc = accepted, same cycle (combinational). wdata = req_data slice g whenever BUSY, 0 otherwise.
  - Each accepted beat increments beat_cnt.
- BUSY → IDLE occurs on whichever happens first:
  - the accepted beat that makes beat_cnt reach BURST_LEN, or
  - req_valid[g]=0 in any BUSY cycle; no beat is taken that cycle.
- On release, rr_ptr takes g, grant clears, and the next arbitration happens in the following IDLE cycle.
- wfull high in BUSY:
  - req_ready[g]=0 and winc=0.
  - The grant is held and beat_cnt is frozen.
  - Stall cycles do not count toward BURST_LEN.
- wfull never produces winc=1. Writes into a full FIFO are impossible by construction.
- grant_valid=(state==BUSY); grant_id = encoded g.
- The arbiter never reorders or duplicates data: each handshake produces exactly one winc.
- Requirement on requesters: once req_valid is high, it is held with stable data until accepted. The bench checks this as an assumption.
- BURST_LEN=1 degenerates to per-beat round-robin with a bubble between beats.

Test Plan:
- Reset check: assert wrst mid-sim with req0 valid → same cycle req_ready=0, winc=0, grant_valid=0. After release, the first grant goes to req0.
- Single burst: req1 valid with 6 beats (0x10..0x15), BURST_LEN=4, wfull=0 →
  - IDLE bubble, then winc on 4 consecutive cycles with 0x10..0x13.
  - Release, one bubble, re-grant req1, then 0x14, 0x15.
- Round-robin: req0, req2, req3 continuously valid, BURST_LEN=2 → grant_id sequence 0,2,3,0, each holding exactly 2 beats.
- Backpressure: wfull=1 for 3 cycles after beat 2 of a req0 burst → winc=0 and req_ready[0]=0 for those 3 cycles. grant_id stays 0; beats 3–4 follow once wfull=0.
- Early release: req2 drops valid after 1 beat of a 4-beat allowance → returns to IDLE the next cycle. rr_ptr=2, so a pending req3 wins the next arbitration over req0.
- Scoreboard run: random valid/wfull on all 4 requesters for 5000 cycles → per-requester data order preserved, no winc while wfull=1, no requester starved longer than (NUM_REQ-1)*(BURST_LEN+1) grant cycles excluding wfull stalls.
